// File: rtl/bpsk_params_pkg.sv
// Shared numeric defaults for the BPSK datapath blocks.
// Tree depth is derived so every adder-tree user agrees on the pipeline length.
package bpsk_params_pkg;
    localparam int DEF_DATA_WIDTH = 18;
    localparam int DEF_ARRAY_SIZE = 8;
    localparam int DEF_TREE_DEPTH = $clog2(DEF_ARRAY_SIZE);
endpackage

// File: rtl/lpf_integrator_if.sv
// Sample-set in / saturated sum out bus for the LPF integrator.
// The producer/consumer side is master, the integrator is slave.
interface lpf_integrator_if
    import bpsk_params_pkg::*;
#(
    parameter int ARRAY_SIZE = DEF_ARRAY_SIZE,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic                         in_valid;
    logic signed [DATA_WIDTH-1:0] input_array [0:ARRAY_SIZE-1];
    logic signed [DATA_WIDTH-1:0] out;
    logic                         out_valid;

    modport master (output in_valid, input_array, input out, out_valid);
    modport slave  (input in_valid, input_array, output out, out_valid);
endinterface

// File: rtl/lpf_adder_stage.sv
// One registered adder-tree level: sums adjacent pairs with one bit of growth.
// Data only loads on a valid cycle so the result holds between sample sets.
module lpf_adder_stage #(
    parameter int IN_W  = 18,
    parameter int PAIRS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic signed [IN_W-1:0] in_data [0:2*PAIRS-1],
    output logic                  out_valid,
    output logic signed [IN_W:0]   out_data [0:PAIRS-1]
);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            for (int j = 0; j < PAIRS; j++) out_data[j] <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                for (int j = 0; j < PAIRS; j++)
                    out_data[j] <= {in_data[2*j][IN_W-1], in_data[2*j]}
                                 + {in_data[2*j+1][IN_W-1], in_data[2*j+1]};
            end
        end
    end
endmodule

// File: rtl/lpf_integrator.sv
// Pipelined signed sum of a sample set followed by a registered saturator.
// Latency is tree depth + 1; one sample set accepted per cycle.
module lpf_integrator
    import bpsk_params_pkg::*;
#(
    parameter int ARRAY_SIZE = DEF_ARRAY_SIZE,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    lpf_integrator_if.slave  bus
);
    localparam int DEPTH = $clog2(ARRAY_SIZE);
    localparam int SUM_W = DATA_WIDTH + DEPTH;
    localparam logic signed [SUM_W-1:0] SAT_MAX = {{(DEPTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN = {{(DEPTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    // vld_pipe[l] qualifies the operands entering tree level l
    logic [DEPTH:0] vld_pipe;
    assign vld_pipe[0] = bus.in_valid;

    for (genvar l = 0; l < DEPTH; l++) begin : gen_lvl
        localparam int W = DATA_WIDTH + l;
        localparam int P = ARRAY_SIZE >> (l + 1);
        logic signed [W-1:0] opnd [0:2*P-1];
        logic signed [W:0]   sum  [0:P-1];

        if (l == 0) begin : g_head
            assign opnd = bus.input_array;
        end else begin : g_chain
            assign opnd = gen_lvl[l-1].sum;
        end

        lpf_adder_stage #(.IN_W(W), .PAIRS(P)) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (vld_pipe[l]),
            .in_data  (opnd),
            .out_valid(vld_pipe[l+1]),
            .out_data (sum)
        );
    end

    logic signed [SUM_W-1:0]      total;
    logic signed [DATA_WIDTH-1:0] sat;
    assign total = gen_lvl[DEPTH-1].sum[0];

    always_comb begin
        sat = total[DATA_WIDTH-1:0];
        if (total > SAT_MAX)      sat = SAT_MAX[DATA_WIDTH-1:0];
        else if (total < SAT_MIN) sat = SAT_MIN[DATA_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.out       <= '0;
            bus.out_valid <= 1'b0;
        end else begin
            bus.out_valid <= vld_pipe[DEPTH];
            if (vld_pipe[DEPTH]) bus.out <= sat;
        end
    end
endmodule

// File: tb/tb_lpf_integrator.sv
// Directed bench for lpf_integrator (ARRAY_SIZE=8, DATA_WIDTH=18).
// Drives and samples on the falling edge; expected sums are hand-computed.
module tb_lpf_integrator;
    typedef logic signed [17:0] set_t [0:7];

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    lpf_integrator_if #(.ARRAY_SIZE(8), .DATA_WIDTH(18)) bus ();

    lpf_integrator #(.ARRAY_SIZE(8), .DATA_WIDTH(18)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic chk(input string tag, input logic signed [31:0] act, input logic signed [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask

    task automatic fill(output set_t s, input int v);
        for (int i = 0; i < 8; i++) s[i] = 18'(v);
    endtask

    task automatic scramble();
        for (int i = 0; i < 8; i++) bus.input_array[i] = 18'($urandom);
    endtask

    // Inject one set at a falling edge, then check latency, value and hold.
    task automatic run_set(input string tag, input set_t s, input int expv);
        bus.in_valid    = 1'b1;
        bus.input_array = s;
        @(negedge clk);
        bus.in_valid = 1'b0;
        scramble();
        repeat (2) @(negedge clk);
        chk({tag, "_early"}, 32'(bus.out_valid), 0);
        @(negedge clk);
        chk({tag, "_vld"}, 32'(bus.out_valid), 1);
        chk({tag, "_out"}, bus.out, expv);
        scramble();
        @(negedge clk);
        chk({tag, "_vld_drop"}, 32'(bus.out_valid), 0);
        chk({tag, "_hold"}, bus.out, expv);
    endtask

    initial begin
        set_t s;
        int   pulses;
        logic signed [17:0] held;

        bus.in_valid = 1'b1;
        scramble();
        repeat (2) @(negedge clk);
        chk("rst_out", bus.out, 0);
        chk("rst_vld", 32'(bus.out_valid), 0);
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) s[i] = 18'(i * 1024);
        run_set("ramp", s, 28672);

        fill(s, 131071);  run_set("sat_pos", s, 131071);
        fill(s, -131072); run_set("sat_neg", s, -131072);

        for (int i = 0; i < 8; i++) s[i] = (i % 2 == 0) ? 18'sd1000 : -18'sd1000;
        run_set("alt", s, 0);

        fill(s, 0); s[0] = -18'sd5; s[1] = 18'sd3; s[7] = 18'sd1;
        run_set("small_neg", s, -1);

        fill(s, 0); s[0] = 18'sd131071;
        run_set("edge_max", s, 131071);
        s[1] = 18'sd1;
        run_set("edge_over", s, 131071);
        fill(s, 0); s[0] = -18'sd131072; s[3] = -18'sd1;
        run_set("edge_under", s, -131072);

        // Back-to-back sets: set k all k, result 8k appears four edges later.
        for (int k = 0; k < 8; k++) begin
            fill(s, k);
            bus.in_valid    = 1'b1;
            bus.input_array = s;
            @(negedge clk);
            if (k >= 3) begin
                chk($sformatf("b2b_vld%0d", k - 3), 32'(bus.out_valid), 1);
                chk($sformatf("b2b_out%0d", k - 3), bus.out, (k - 3) * 8);
            end
        end
        bus.in_valid = 1'b0;
        for (int m = 5; m < 8; m++) begin
            @(negedge clk);
            chk($sformatf("b2b_vld%0d", m), 32'(bus.out_valid), 1);
            chk($sformatf("b2b_out%0d", m), bus.out, m * 8);
        end
        @(negedge clk);
        chk("b2b_end", 32'(bus.out_valid), 0);

        // Reset two cycles after capture must swallow the in-flight set.
        fill(s, 1000);
        bus.in_valid    = 1'b1;
        bus.input_array = s;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_out", bus.out, 0);
        chk("midrst_vld", 32'(bus.out_valid), 0);
        rst_n  = 1'b1;
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.out_valid) pulses++;
        end
        chk("midrst_ghost", pulses, 0);

        fill(s, -7);
        run_set("post_rst", s, -56);

        // Idle inputs churn without in_valid: output must not move.
        held   = bus.out;
        pulses = 0;
        repeat (6) begin
            scramble();
            @(negedge clk);
            if (bus.out_valid) pulses++;
            if (bus.out !== held) pulses++;
        end
        chk("idle_stable", pulses, 0);
        chk("idle_out", bus.out, -56);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
